// File: rtl/uart_spi_cmd_ctrl.sv
// UART-to-SPI command controller: collects an address/data/opcode frame from the UART,
// starts one EEPROM write or read, and answers with an ACK, the read byte, or a NAK.
module uart_spi_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter logic [7:0]  OP_WR       = 8'hA5,
   parameter logic [7:0]  OP_RD       = 8'hA1,
   parameter logic [7:0]  RSP_ACK     = 8'h5A,
   parameter logic [7:0]  RSP_NAK     = 8'hEE
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       spi_busy,
   input  logic       spi_rd_done,
   input  logic [7:0] spi_rd_data,
   input  logic       tx_done,
   output logic       spi_wr,
   output logic       spi_rd,
   output logic [7:0] spi_addr,
   output logic [7:0] spi_data,
   output logic [7:0] tx_data,
   output logic       tx_send,
   output logic       cmd_err,
   output logic       ctrl_busy
);

   localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, GET_DATA, GET_OP, ISSUE, WAIT_SPI, SEND_RSP, WAIT_TX
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    spi_addr_q, spi_addr_d;
   logic [7:0]    spi_data_q, spi_data_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          is_rd_q, is_rd_d;
   logic          first_q, first_d;

   logic [CW-1:0] cnt_inc;
   logic          timeout;
   logic          op_ok;
   logic          wr_cpl;
   logic          rd_cpl;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
   assign timeout = (cnt_q >= CNT_LAST);
   assign op_ok   = (rx_data == OP_WR) || ((rx_data == OP_RD) && (spi_data_q == 8'hFF));
   // busy is meaningless in the first WAIT_SPI cycle while the engine registers the start pulse
   assign wr_cpl  = !is_rd_q && !first_q && !spi_busy;
   assign rd_cpl  = is_rd_q && spi_rd_done;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         spi_addr_q <= 8'h00;
         spi_data_q <= 8'h00;
         tx_data_q  <= 8'h00;
         is_rd_q    <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         spi_addr_q <= spi_addr_d;
         spi_data_q <= spi_data_d;
         tx_data_q  <= tx_data_d;
         is_rd_q    <= is_rd_d;
         first_q    <= first_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      spi_addr_d = spi_addr_q;
      spi_data_d = spi_data_q;
      tx_data_d  = tx_data_q;
      is_rd_d    = is_rd_q;
      first_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rx_done) begin
               spi_addr_d = rx_data;
               state_d    = GET_DATA;
            end
         end
         GET_DATA: begin
            if (rx_done) begin
               spi_data_d = rx_data;
               state_d    = GET_OP;
            end else if (timeout) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         GET_OP: begin
            if (rx_done) begin
               is_rd_d = (rx_data == OP_RD);
               if (op_ok) begin
                  state_d = ISSUE;
               end else begin
                  tx_data_d = RSP_NAK;
                  state_d   = SEND_RSP;
               end
            end else if (timeout) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         // the counter keeps running from ISSUE into WAIT_SPI, bounding the whole SPI transaction
         ISSUE: begin
            if (!spi_busy) begin
               cnt_d   = cnt_inc;
               first_d = 1'b1;
               state_d = WAIT_SPI;
            end else if (timeout) begin
               tx_data_d = RSP_NAK;
               state_d   = SEND_RSP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_SPI: begin
            if (rd_cpl) begin
               tx_data_d = spi_rd_data;
               state_d   = SEND_RSP;
            end else if (wr_cpl) begin
               tx_data_d = RSP_ACK;
               state_d   = SEND_RSP;
            end else if (timeout) begin
               tx_data_d = RSP_NAK;
               state_d   = SEND_RSP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SEND_RSP: state_d = WAIT_TX;
         WAIT_TX: begin
            if (tx_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      spi_wr  = 1'b0;
      spi_rd  = 1'b0;
      cmd_err = 1'b0;
      unique case (state_q)
         GET_DATA: cmd_err = !rx_done && timeout;
         GET_OP:   cmd_err = rx_done ? !op_ok : timeout;
         ISSUE: begin
            if (!spi_busy) begin
               spi_wr = !is_rd_q;
               spi_rd = is_rd_q;
            end else begin
               cmd_err = timeout;
            end
         end
         WAIT_SPI: cmd_err = !rd_cpl && !wr_cpl && timeout;
         default: cmd_err = 1'b0;
      endcase
   end

   assign tx_send   = (state_q == SEND_RSP);
   assign ctrl_busy = (state_q != IDLE);
   assign spi_addr  = spi_addr_q;
   assign spi_data  = spi_data_q;
   assign tx_data   = tx_data_q;

endmodule
